// File: rtl/prl_tx_scheduler.sv
// ---------------------------------------------------------------------------
// prl_tx_scheduler
// USB-PD protocol-layer transmit scheduler. Arbitrates the single PHY
// transmit port between GoodCRC replies requested by the Rx FSM (always
// first) and policy-engine messages. PE messages get the MessageID
// inserted, then wait for the partner's GoodCRC under CRCReceiveTimer, with
// up to N_RETRY retransmissions before reporting failure.
//
// Ports
//   CLK, reset        clock; synchronous active-high reset
//   soft_reset        protocol soft reset (same effect as reset)
//   gcrc_req/gcrc_id  Rx FSM GoodCRC request (level) and id to echo
//   gcrc_ack          pulse: GoodCRC fully sent
//   pe_req/pe_hdr     PE submit pulse and header ([11:9] replaced)
//   pe_busy           PE message pending or in flight
//   phy_tx_valid/hdr  transmit request to PHY, held until phy_tx_done
//   phy_tx_done       PHY finished transmitting
//   phy_busy          line busy, no new transmission may start
//   rx_gcrc_valid/id  GoodCRC received from the partner
//   tx_success/fail   PE message outcome pulses
//   msg_id            current MessageIDCounter
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | nothing on the PHY; arbitrate GoodCRC over pending PE message
// GCRC_TX  | GoodCRC reply on the PHY, waiting for phy_tx_done
// MSG_TX   | PE message on the PHY, waiting for phy_tx_done
// WAIT_CRC | CRCReceiveTimer running, waiting for partner's GoodCRC
// ---------------------------------------------------------------------------
module prl_tx_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 10,
  parameter int unsigned N_RETRY        = 2,
  parameter logic [3:0]  ROLE_BITS      = 4'b0010
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        soft_reset,
  input  logic        gcrc_req,
  input  logic [2:0]  gcrc_id,
  output logic        gcrc_ack,
  input  logic        pe_req,
  input  logic [15:0] pe_hdr,
  output logic        pe_busy,
  output logic        phy_tx_valid,
  output logic [15:0] phy_tx_hdr,
  input  logic        phy_tx_done,
  input  logic        phy_busy,
  input  logic        rx_gcrc_valid,
  input  logic [2:0]  rx_gcrc_id,
  output logic        tx_success,
  output logic        tx_fail,
  output logic [2:0]  msg_id
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = (N_RETRY < 1) ? 1 : $clog2(N_RETRY + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(N_RETRY);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GCRC_TX  = 2'd1,
    MSG_TX   = 2'd2,
    WAIT_CRC = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic          pending, pending_nxt;
  logic [15:0]   hdr_q, hdr_q_nxt;
  logic [RW-1:0] retry_cnt, retry_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [2:0]    msg_id_nxt;
  logic          phy_tx_valid_nxt;
  logic [15:0]   phy_tx_hdr_nxt;
  logic          gcrc_ack_nxt;
  logic          tx_success_nxt;
  logic          tx_fail_nxt;
  logic [15:0]   gcrc_hdr;
  logic [15:0]   msg_hdr;
  logic          id_match;

  assign pe_busy  = pending;
  assign gcrc_hdr = {1'b0, 3'b000, gcrc_id, ROLE_BITS, 5'b00001};
  // MessageID lives in header bits [11:9]; whatever the PE put there is discarded.
  assign msg_hdr  = (hdr_q & 16'hF1FF) | {4'b0000, msg_id, 9'b0};
  assign id_match = rx_gcrc_valid && (rx_gcrc_id == msg_id);

  always_ff @(posedge CLK) begin
    if (reset || soft_reset) begin
      state        <= IDLE;
      pending      <= 1'b0;
      hdr_q        <= 16'h0000;
      retry_cnt    <= '0;
      timer        <= '0;
      msg_id       <= 3'd0;
      phy_tx_valid <= 1'b0;
      phy_tx_hdr   <= 16'h0000;
      gcrc_ack     <= 1'b0;
      tx_success   <= 1'b0;
      tx_fail      <= 1'b0;
    end else begin
      state        <= state_nxt;
      pending      <= pending_nxt;
      hdr_q        <= hdr_q_nxt;
      retry_cnt    <= retry_nxt;
      timer        <= timer_nxt;
      msg_id       <= msg_id_nxt;
      phy_tx_valid <= phy_tx_valid_nxt;
      phy_tx_hdr   <= phy_tx_hdr_nxt;
      gcrc_ack     <= gcrc_ack_nxt;
      tx_success   <= tx_success_nxt;
      tx_fail      <= tx_fail_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    pending_nxt      = pending;
    hdr_q_nxt        = hdr_q;
    retry_nxt        = retry_cnt;
    timer_nxt        = timer;
    msg_id_nxt       = msg_id;
    phy_tx_valid_nxt = phy_tx_valid;
    phy_tx_hdr_nxt   = phy_tx_hdr;
    gcrc_ack_nxt     = 1'b0;
    tx_success_nxt   = 1'b0;
    tx_fail_nxt      = 1'b0;

    // Accepting a new PE message is independent of the FSM so that a
    // request arriving alongside a GoodCRC dispatch is still captured.
    if (pe_req && !pending) begin
      pending_nxt = 1'b1;
      hdr_q_nxt   = pe_hdr;
      retry_nxt   = '0;
    end

    case (state)
      IDLE: begin
        // gcrc_req is still high in the cycle gcrc_ack is out; the Rx FSM
        // only drops it afterwards, so ignore it then to avoid a duplicate.
        if (gcrc_req && !gcrc_ack && !phy_busy) begin
          state_nxt        = GCRC_TX;
          phy_tx_valid_nxt = 1'b1;
          phy_tx_hdr_nxt   = gcrc_hdr;
        end else if (pending && !phy_busy) begin
          state_nxt        = MSG_TX;
          phy_tx_valid_nxt = 1'b1;
          phy_tx_hdr_nxt   = msg_hdr;
        end
      end

      GCRC_TX: begin
        if (phy_tx_done) begin
          state_nxt        = IDLE;
          phy_tx_valid_nxt = 1'b0;
          phy_tx_hdr_nxt   = 16'h0000;
          gcrc_ack_nxt     = 1'b1;
        end
      end

      MSG_TX: begin
        if (phy_tx_done) begin
          state_nxt        = WAIT_CRC;
          phy_tx_valid_nxt = 1'b0;
          phy_tx_hdr_nxt   = 16'h0000;
          timer_nxt        = TIMER_LOAD;
        end
      end

      WAIT_CRC: begin
        if (timer != '0) begin
          timer_nxt = timer - TW'(1);
        end
        // A matching GoodCRC wins over an expiry in the same cycle.
        if (id_match) begin
          state_nxt      = IDLE;
          tx_success_nxt = 1'b1;
          msg_id_nxt     = msg_id + 3'd1;
          pending_nxt    = 1'b0;
          timer_nxt      = '0;
        end else if (timer == '0) begin
          state_nxt = IDLE;
          if (retry_cnt < RETRY_MAX) begin
            retry_nxt = retry_cnt + RW'(1);
          end else begin
            tx_fail_nxt = 1'b1;
            msg_id_nxt  = msg_id + 3'd1;
            pending_nxt = 1'b0;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/prl_tx_scheduler.md
# prl_tx_scheduler

Protocol-layer transmit scheduler for the USB-PD receive/transmit path. Shares the single PHY transmit port between two requesters: the receive state machine (GoodCRC replies, highest priority) and the policy engine (outgoing messages). For policy-engine messages it inserts the MessageID, then waits for the partner's GoodCRC under CRCReceiveTimer. It retries up to N_RETRY times and reports success or failure.

## Interface
- TIMEOUT_CYCLES, 10: CRCReceiveTimer length in CLK cycles (≥2).
- N_RETRY, 2: retransmissions after the first attempt (nRetryCount).
- ROLE_BITS, 4'b0010: header bits [8:5] (power role, spec revision, data role) used in GoodCRC headers.

- CLK  in  1  clock.
- reset  in  1  synchronous, active-high.
- soft_reset  in  1  synchronous protocol soft reset; clears MessageID and aborts.
- gcrc_req  in  1  level; Rx FSM requests a GoodCRC; held until gcrc_ack.
- gcrc_id  in  3  MessageID to echo in the GoodCRC; stable while gcrc_req is high.
- gcrc_ack  out  1  one-cycle pulse; GoodCRC fully sent.
- pe_req  in  1  one-cycle pulse; policy engine submits a message.
- pe_hdr  in  16  message header; bits [11:9] are ignored and replaced.
- pe_busy  out  1  high while a PE message is pending or in flight.
- phy_tx_valid  out  1  transmit request to PHY; held until phy_tx_done.
- phy_tx_hdr  out  16  header to transmit; stable while phy_tx_valid is high.
- phy_tx_done  in  1  one-cycle pulse; PHY finished transmitting.
- phy_busy  in  1  line busy; no new transmission may start.
- rx_gcrc_valid  in  1  one-cycle pulse; GoodCRC received from partner.
- rx_gcrc_id  in  3  MessageID of the received GoodCRC.
- tx_success  out  1  one-cycle pulse.
- tx_fail  out  1  one-cycle pulse.
- msg_id  out  3  current MessageIDCounter.

## Operation
- States: IDLE, GCRC_TX, MSG_TX, WAIT_CRC.
- Pending register: on pe_req with pe_busy=0, latch pe_hdr, set pending, clear retry_cnt, and raise pe_busy. A pe_req while pe_busy=1 is dropped.
- IDLE:
  - If gcrc_req and !phy_busy, go to GCRC_TX.
  - Else if pending and !phy_busy, go to MSG_TX.
  - GoodCRC always wins a simultaneous decision.
  - A pe_req arriving in the same cycle as a dispatch is latched, not lost.
- GCRC_TX:
  - phy_tx_valid=1, phy_tx_hdr={1'b0,3'b000,gcrc_id,ROLE_BITS,5'b00001}.
  - On phy_tx_done, go to IDLE and pulse gcrc_ack.
- MSG_TX:
  - phy_tx_valid=1, phy_tx_hdr=pe_hdr with [11:9]=msg_id.
  - On phy_tx_done, go to WAIT_CRC and load timer=TIMEOUT_CYCLES.
- WAIT_CRC: timer decrements each cycle.
  - rx_gcrc_valid with rx_gcrc_id==msg_id: pulse tx_success, msg_id+1 mod 8, clear pending, go to IDLE.
  - rx_gcrc_valid with a mismatched id is ignored.
  - Timer reaching 0 with retry_cnt<N_RETRY: retry_cnt+1, go to IDLE with pending kept. A queued GoodCRC may be served before the retry.
  - Timer reaching 0 with retry_cnt==N_RETRY: pulse tx_fail, msg_id+1 mod 8, clear pending, go to IDLE.
  - A matching GoodCRC in the same cycle as expiry counts as success.
- gcrc_req is not served outside IDLE; it stays pending.
- soft_reset has the same effect as reset (below), with no tx_fail pulse.
- Reset values: state IDLE, msg_id 0, pending 0, retry_cnt 0, timer 0, all outputs 0 (phy_tx_hdr 16'h0000).

## Timing
- All outputs are registered.
- Dispatch: condition sampled at edge k, then phy_tx_valid=1 and phy_tx_hdr valid from cycle k+1.
- Completion: phy_tx_done high at edge k gives phy_tx_valid=0 at k+1. gcrc_ack (or WAIT_CRC entry) also takes effect at k+1.
- The earliest next phy_tx_valid is k+2.
- Timeout: with no GoodCRC, expiry is TIMEOUT_CYCLES cycles after WAIT_CRC entry. tx_fail/retry takes effect the following cycle.
- tx_success: asserted the cycle after the matching rx_gcrc_valid; msg_id updates on the same edge.
- pe_busy: rises the cycle after an accepted pe_req; falls together with the tx_success or tx_fail pulse.
- reset or soft_reset mid-transmission: phy_tx_valid drops the next cycle; a later phy_tx_done is ignored.

## Test plan
- pe_req, hdr 16'h1041 → phy_tx_hdr 16'h1041 with [11:9]=0. Done, then rx_gcrc id 0 → tx_success pulse, msg_id=1, pe_busy=0.
- gcrc_req (id 5) and pe_req in the same cycle → GoodCRC hdr 16'h0A41 sent first. Then gcrc_ack, then the PE message goes out with msg_id 0.
- No GoodCRC, N_RETRY=2 → 3 transmissions, each retry spaced by TIMEOUT_CYCLES; tx_fail once; msg_id=1.
- rx_gcrc id 3 while msg_id=0 → ignored; timer still expires and a retry is issued.
- phy_busy=1 with pending request → no phy_tx_valid. phy_busy drops → valid the next cycle.
- soft_reset during WAIT_CRC with msg_id=4 → IDLE, msg_id=0, pe_busy=0, no tx_success/tx_fail pulse.
